asuna_sdiv_seq: RTL and testbench

Issue/collect sequencer that wraps the pipelined 32x32 signed divider (fixed latency, always ready, no tag). Accepts tagged divide requests over a valid/ready handshake and issues them to the divider. A sideband shift line carries each request's tag and dividend sign beside it. Returned quotient/remainder are converted to two's complement, RISC-V special cases are applied, and results are queued in a credit-protected FIFO for a back-pressured consumer.

---
 rtl/asuna_sdiv_pkg.sv | 37 +++
 rtl/asuna_sdiv_rfifo.sv | 96 +++++++++
 rtl/asuna_sdiv_seq.sv | 172 +++++++++++++++++
 tb/tb_asuna_sdiv_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asuna_sdiv_pkg.sv
// Shared types and constants for the signed-divide issue/collect sequencer.
package asuna_sdiv_pkg;

    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [1:0]  EXC_NONE   = 2'b00;
    localparam logic [1:0]  EXC_DIV0   = 2'b01;
    localparam logic [1:0]  EXC_OVF    = 2'b10;
    localparam int unsigned SDIV_TAG_W = 4;

    typedef struct packed {
        logic                  valid;
        logic [SDIV_TAG_W-1:0] tag;
        logic                  a_sign;
        logic                  zero;
        logic                  ovf;
        logic [31:0]           a;
    } sdiv_side_t;

    typedef struct packed {
        logic [31:0]           q;
        logic [31:0]           r;
        logic [SDIV_TAG_W-1:0] tag;
        logic [1:0]            exc;
    } sdiv_res_t;

    // Sign-magnitude (31-bit magnitude) to 32-bit two's complement.
    function automatic logic [31:0] sm_to_tc(input logic neg, input logic [30:0] mag);
        logic [31:0] ext;
        ext = {1'b0, mag};
        if (neg) begin
            sm_to_tc = 32'd0 - ext;
        end else begin
            sm_to_tc = ext;
        end
    endfunction

endpackage

// File: rtl/asuna_sdiv_rfifo.sv
// Result FIFO whose head entry and valid flag are held in output registers.
module asuna_sdiv_rfifo
    import asuna_sdiv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  sdiv_res_t        data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output sdiv_res_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    sdiv_res_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    sdiv_res_t        head_q, head_d;
    logic             do_pop_s;
    logic             do_push_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Pointer/count bookkeeping and next head selection (bypass when the write lands on the new head).
    always_comb begin
        do_pop_s  = pop_i && valid_q;
        do_push_s = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = '0;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != CNT_W'(0));
        if (!valid_d) begin
            head_d = '0;
        end else if (do_push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage, pointers and registered head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/asuna_sdiv_seq.sv
// Issue/collect sequencer around a fixed-latency signed divider: credit-limited issue,
// sideband alignment, RISC-V special-case fixup and a result FIFO.
module asuna_sdiv_seq
    import asuna_sdiv_pkg::*;
#(
    parameter int unsigned LATENCY = 34,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = SDIV_TAG_W
) (
    input  logic             system_clock,
    input  logic             system_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_req,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    input  logic             div_done,
    input  logic [31:0]      div_q,
    input  logic [31:0]      div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_q,
    output logic [31:0]      out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_exc,
    output logic             err_sync
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic             in_ready_q, in_ready_d;
    logic             div_req_q, div_req_d;
    logic [31:0]      div_a_q, div_a_d;
    logic [31:0]      div_b_q, div_b_d;
    sdiv_side_t       issue_q, issue_d;
    sdiv_side_t       side_q [LATENCY];
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    logic             accept_s;
    logic             collect_s;
    logic             pop_s;
    sdiv_side_t       last_s;
    sdiv_res_t        res_s;
    sdiv_res_t        head_s;
    logic             fifo_valid_s;
    logic [CNT_W-1:0] fifo_cnt_s, fifo_cnt_d;
    logic             zero_s, ovf_s;
    logic             unused_s;

    assign unused_s = div_r[31];
    assign last_s   = side_q[LATENCY-1];

    // Issue side: accept, operand registers and sideband entry for the new request.
    always_comb begin
        accept_s = in_valid && in_ready_q;
        zero_s   = (in_b == 32'h0000_0000);
        ovf_s    = (in_a == INT_MIN) && (in_b == 32'hFFFF_FFFF);
        issue_d  = '0;
        div_req_d = accept_s;
        if (accept_s) begin
            div_a_d        = in_a;
            div_b_d        = in_b;
            issue_d.valid  = 1'b1;
            issue_d.tag    = SDIV_TAG_W'(in_tag);
            issue_d.a_sign = in_a[31];
            issue_d.zero   = zero_s;
            issue_d.ovf    = ovf_s;
            issue_d.a      = zero_s ? in_a : 32'h0000_0000;
        end else begin
            div_a_d = div_a_q;
            div_b_d = div_b_q;
        end
    end

    // Collect side: result fixup, credit accounting and sync-error detection.
    always_comb begin
        collect_s = div_done && last_s.valid;
        pop_s     = fifo_valid_s && out_ready;
        res_s.tag = last_s.tag;
        if (last_s.zero) begin
            res_s.q   = 32'hFFFF_FFFF;
            res_s.r   = last_s.a;
            res_s.exc = EXC_DIV0;
        end else if (last_s.ovf) begin
            res_s.q   = INT_MIN;
            res_s.r   = 32'h0000_0000;
            res_s.exc = EXC_OVF;
        end else begin
            res_s.q   = sm_to_tc(div_q[31], div_q[30:0]);
            res_s.r   = sm_to_tc(last_s.a_sign, div_r[30:0]);
            res_s.exc = EXC_NONE;
        end
        case ({accept_s, collect_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({collect_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_s + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_s - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_s;
        endcase
        // Ready is registered from next-state counts so it always matches current credit.
        in_ready_d = ({1'b0, inflight_d} + {1'b0, fifo_cnt_d}) < SUM_W'(DEPTH);
        err_d      = err_q | (div_done != last_s.valid);
    end

    // Issue registers, counters and sticky error.
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            in_ready_q <= 1'b0;
            div_req_q  <= 1'b0;
            div_a_q    <= 32'h0000_0000;
            div_b_q    <= 32'h0000_0000;
            issue_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
            div_req_q  <= div_req_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            issue_q    <= issue_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Sideband shift line; its last stage lines up with div_done.
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                side_q[i] <= '0;
            end
        end else begin
            side_q[0] <= issue_q;
            for (int i = 1; i < LATENCY; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    asuna_sdiv_rfifo #(
        .DEPTH (DEPTH)
    ) u_rfifo (
        .clk_i   (system_clock),
        .rst_i   (system_reset),
        .push_i  (collect_s),
        .data_i  (res_s),
        .pop_i   (pop_s),
        .valid_o (fifo_valid_s),
        .head_o  (head_s),
        .count_o (fifo_cnt_s)
    );

    assign in_ready  = in_ready_q;
    assign div_req   = div_req_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign out_valid = fifo_valid_s;
    assign out_q     = head_s.q;
    assign out_r     = head_s.r;
    assign out_tag   = TAG_W'(head_s.tag);
    assign out_exc   = head_s.exc;
    assign err_sync  = err_q;

endmodule

// File: tb/tb_asuna_sdiv_seq.sv
// Bench for asuna_sdiv_seq: behavioural divider, arithmetic reference model and scoreboard.
module tb_asuna_sdiv_seq;

    localparam int L = 34;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        div_req;
    logic [31:0] div_a, div_b;
    logic        div_done = 1'b0;
    logic [31:0] div_q = 32'd0, div_r = 32'd0;
    logic        out_valid, out_ready;
    logic [31:0] out_q, out_r;
    logic [3:0]  out_tag;
    logic [1:0]  out_exc;
    logic        err_sync;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic [1:0]  exc;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] q;
        logic [31:0] r;
    } dv_t;

    exp_t expq[$];
    dv_t  dq[$];
    int   edge_n = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic inject = 1'b0;

    always #5 clk = ~clk;

    asuna_sdiv_seq #(.LATENCY(L), .DEPTH(D), .TAG_W(4)) dut (
        .system_clock (clk),
        .system_reset (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .div_req      (div_req),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_done     (div_done),
        .div_q        (div_q),
        .div_r        (div_r),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_q        (out_q),
        .out_r        (out_r),
        .out_tag      (out_tag),
        .out_exc      (out_exc),
        .err_sync     (err_sync)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RISC-V signed division semantics from plain arithmetic.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t   e;
        longint sa, sb;
        e.tag = tag;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.exc = 2'b01;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.exc = 2'b10;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
            e.exc = 2'b00;
        end
        return e;
    endfunction

    // Divider model: captures requests and schedules sign-magnitude results L edges later.
    always @(posedge clk) begin
        dv_t         e;
        logic [31:0] ma, mb;
        edge_n++;
        if (rst) begin
            dq.delete();
        end else if (div_req) begin
            ma = div_a[31] ? (32'd0 - div_a) : div_a;
            mb = div_b[31] ? (32'd0 - div_b) : div_b;
            e.due = edge_n + L;
            if (div_b == 32'd0 || (div_a == 32'h8000_0000 && div_b == 32'hFFFF_FFFF)) begin
                e.q = $urandom;
                e.r = $urandom;
            end else begin
                e.q = {div_a[31] ^ div_b[31], 31'(ma / mb)};
                e.r = {1'($urandom), 31'(ma % mb)};
            end
            dq.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (dq.size() > 0 && dq[0].due == edge_n + 1) begin
            div_done = 1'b1;
            div_q    = dq[0].q;
            div_r    = dq[0].r;
            void'(dq.pop_front());
        end else begin
            div_done = inject;
            div_q    = $urandom;
            div_r    = $urandom;
        end
    end

    // Scoreboard: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            chk("sb_has_entry", 128'(expq.size() != 0), 128'(1));
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("result", 128'({out_q, out_r, out_tag, out_exc}), 128'({e.q, e.r, e.tag, e.exc}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int waited;
        waited = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        while (!in_ready && waited < 300) begin
            step();
            waited++;
        end
        chk("send_ready", 128'(in_ready), 128'(1));
        if (in_ready) expq.push_back(model(a, b, tag));
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk("drain_empty", 128'(expq.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int          acc, k, sel;
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_tag = 4'd0; out_ready = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_div", 128'({div_req, div_a, div_b}), 128'(0));
        chk("rst_out", 128'({out_valid, out_q, out_r, out_tag, out_exc, err_sync}), 128'(0));
        rst = 1'b0;
        step();
        chk("ready_after_rst", 128'(in_ready), 128'(1));

        // 7 / -2 with exact latency
        send(32'd7, 32'hFFFF_FFFE, 4'd3);
        repeat (L) step();
        chk("lat_early", 128'(out_valid), 128'(0));
        step();
        chk("lat_valid", 128'(out_valid), 128'(1));
        chk("q_7_m2", 128'({out_q, out_r, out_tag, out_exc}), 128'({32'hFFFF_FFFD, 32'd1, 4'd3, 2'b00}));
        drain();

        send(32'hFFFF_FFF9, 32'd2, 4'd1);
        drain();

        // divide-by-zero then overflow, back to back
        send(32'd5, 32'd0, 4'd7);
        send(32'h8000_0000, 32'hFFFF_FFFF, 4'd8);
        drain();

        // accept on the same edge as an earlier collect
        send(32'd1000, 32'd7, 4'd9);
        repeat (L) step();
        send(32'hFFFF_FC18, 32'd13, 4'd10);
        drain();

        // credit limit with stalled consumer
        out_ready = 1'b0;
        acc = 0; k = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (k < 6);
            in_a = $urandom; in_b = $urandom_range(1, 100); in_tag = 4'(k);
            if (in_valid && in_ready) begin
                expq.push_back(model(in_a, in_b, 4'(k)));
                acc++; k++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("credit_accepted", 128'(acc), 128'(D));
        chk("credit_ready_low", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        send(32'd77, 32'd5, 4'd4);
        send(32'hFFFF_FF00, 32'd3, 4'd5);
        drain();

        // randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid  = ($urandom_range(0, 9) < 7);
            a = $urandom; b = $urandom; sel = $urandom_range(0, 19);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel < 5) b = 32'd0 - 32'($urandom_range(1, 20));
            else if (sel < 9) b = 32'($urandom_range(1, 20));
            if (a == 32'h8000_0000 && b == 32'd1) b = 32'd3;
            in_a = a; in_b = b; in_tag = 4'($urandom);
            if (in_valid && in_ready) expq.push_back(model(a, b, in_tag));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        chk("no_sync_err", 128'(err_sync), 128'(0));

        // reset with requests in flight
        send(32'd11, 32'd2, 4'd1);
        send(32'd12, 32'd3, 4'd2);
        send(32'd13, 32'd4, 4'd3);
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("midrst_ready", 128'(in_ready), 128'(0));
        chk("midrst_out", 128'({out_valid, out_q, out_r, out_tag, out_exc, err_sync, div_req}), 128'(0));
        expq.delete();
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (L + 6) begin
            step();
            seen = seen | out_valid;
        end
        chk("no_out_after_rst", 128'(seen), 128'(0));
        chk("err_clear", 128'(err_sync), 128'(0));

        // unmatched div_done
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("err_set", 128'(err_sync), 128'(1));
        repeat (3) step();
        chk("err_sticky", 128'(err_sync), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
